systolic_feeder: RTL and testbench

//  Drive side of the 2x2 systolic_array. Latches two signed 2x2 operand matrices on a

---
 rtl/systolic_pkg.sv | 29 ++
 rtl/systolic_feeder.sv | 149 ++++++++++++++
 tb/tb_systolic_feeder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared constants for the 2x2 systolic feeder:
//   - default operand/result widths and drain length
//   - FSM state encoding (IDLE, CLEAR, FEED0..2, DRAIN, CAPTURE)
//   - element index constants for the packed {X11,X12,X21,X22} matrix words
//     (X11 sits in the most significant slot)
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int ACC_W_DEF        = 18;
  localparam int DRAIN_CYCLES_DEF = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_FEED0   = 3'd2;
  localparam logic [2:0] ST_FEED1   = 3'd3;
  localparam logic [2:0] ST_FEED2   = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;
  localparam logic [2:0] ST_CAPTURE = 3'd6;

  // Slot of each element inside a packed 2x2 matrix word.
  localparam int EL_11 = 3;
  localparam int EL_12 = 2;
  localparam int EL_21 = 1;
  localparam int EL_22 = 0;

endpackage

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//   Drive side of a 2x2 output-stationary systolic array. On an accepted start
//   it latches both operand matrices, pulses array_clr for one cycle, emits the
//   skewed a1/a2/b1/b2 wavefront over three cycles, holds zeros while the array
//   drains, then captures the four accumulators into c_mat and pulses done.
//
// Ports
//   clk                 clock
//   rst                 synchronous, active-low reset
//   start               job request, only honoured in IDLE
//   a_mat, b_mat        {X11,X12,X21,X22} signed operands, X11 in the MSBs
//   busy                high from the cycle after acceptance until done
//   done                one-cycle pulse, c_mat valid from this cycle on
//   c_mat               {C11,C12,C21,C22}, held until the next done
//   array_clr           active-high clear for the array accumulators
//   a1, a2, b1, b2      row/column operands into the array
//   c11, c12, c21, c22  array accumulator outputs
// -----------------------------------------------------------------------------
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ACC_W        = ACC_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DATA_W-1:0]   a_mat,
  input  logic [4*DATA_W-1:0]   b_mat,
  output logic                  busy,
  output logic                  done,
  output logic [4*ACC_W-1:0]    c_mat,
  output logic                  array_clr,
  output logic [DATA_W-1:0]     a1,
  output logic [DATA_W-1:0]     a2,
  output logic [DATA_W-1:0]     b1,
  output logic [DATA_W-1:0]     b2,
  input  logic [ACC_W-1:0]      c11,
  input  logic [ACC_W-1:0]      c12,
  input  logic [ACC_W-1:0]      c21,
  input  logic [ACC_W-1:0]      c22
);

  localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [4*DATA_W-1:0]   a_reg;
  logic [4*DATA_W-1:0]   b_reg;
  logic [CNT_W-1:0]      drain_cnt;
  logic [DATA_W-1:0]     a1_nxt, a2_nxt, b1_nxt, b2_nxt;

  function automatic logic [DATA_W-1:0] el(input logic [4*DATA_W-1:0] m, input int idx);
    return m[idx*DATA_W +: DATA_W];
  endfunction

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_CLEAR;
      ST_CLEAR:   state_nxt = ST_FEED0;
      ST_FEED0:   state_nxt = ST_FEED1;
      ST_FEED1:   state_nxt = ST_FEED2;
      ST_FEED2:   state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt == '0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Skew schedule. Outputs are registered, so the mux is driven by the state
  // being entered: the array sees FEEDn operands for exactly the FEEDn cycle.
  always_comb begin
    a1_nxt = '0;
    a2_nxt = '0;
    b1_nxt = '0;
    b2_nxt = '0;
    case (state_nxt)
      ST_FEED0: begin
        a1_nxt = el(a_reg, EL_11);
        b1_nxt = el(b_reg, EL_11);
      end
      ST_FEED1: begin
        a1_nxt = el(a_reg, EL_12);
        b1_nxt = el(b_reg, EL_21);
        a2_nxt = el(a_reg, EL_21);
        b2_nxt = el(b_reg, EL_12);
      end
      ST_FEED2: begin
        a2_nxt = el(a_reg, EL_22);
        b2_nxt = el(b_reg, EL_22);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: operand registers are small and reset alongside control so a
      // job can never pick up stale operands after an abort.
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      c_mat     <= '0;
      array_clr <= 1'b0;
      a1        <= '0;
      a2        <= '0;
      b1        <= '0;
      b2        <= '0;
    end else begin
      state     <= state_nxt;
      array_clr <= (state_nxt == ST_CLEAR);
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state == ST_CAPTURE);
      a1        <= a1_nxt;
      a2        <= a2_nxt;
      b1        <= b1_nxt;
      b2        <= b2_nxt;

      // Operands are frozen at acceptance; later a_mat/b_mat changes are ignored.
      if (state == ST_IDLE && start) begin
        a_reg <= a_mat;
        b_reg <= b_mat;
      end

      // DRAIN lasts drain_cnt+1 cycles: loaded on FEED2 exit, counted to zero.
      if (state == ST_FEED2) begin
        drain_cnt <= CNT_W'(DRAIN_CYCLES);
      end else if (state == ST_DRAIN && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - 1'b1;
      end

      if (state == ST_CAPTURE) begin
        c_mat <= {c11, c12, c21, c22};
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//   Drives systolic_feeder into a behavioural 2x2 output-stationary array and
//   checks the wavefront, timing, handshake and captured products against
//   matrix arithmetic computed here.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int DW  = 8;
  localparam int AW  = 18;
  localparam int DRN = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [4*DW-1:0] a_mat, b_mat;
  logic            busy, done, array_clr;
  logic [4*AW-1:0] c_mat;
  logic [DW-1:0]   a1, a2, b1, b2;
  logic signed [AW-1:0] c11, c12, c21, c22;

  int checks = 0;
  int errors = 0;

  systolic_feeder #(.DATA_W(DW), .ACC_W(AW), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .rst(rst), .start(start), .a_mat(a_mat), .b_mat(b_mat),
    .busy(busy), .done(done), .c_mat(c_mat), .array_clr(array_clr),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22)
  );

  always #5 clk = ~clk;

  // Behavioural systolic array: a flows right, b flows down, each PE accumulates.
  logic signed [DW-1:0] ra11, ra21, db11, db12;
  always_ff @(posedge clk) begin
    if (!rst || array_clr) begin
      c11 <= '0; c12 <= '0; c21 <= '0; c22 <= '0;
      ra11 <= '0; ra21 <= '0; db11 <= '0; db12 <= '0;
    end else begin
      c11  <= c11 + $signed(a1) * $signed(b1);
      c12  <= c12 + ra11 * $signed(b2);
      c21  <= c21 + $signed(a2) * db11;
      c22  <= c22 + ra21 * db12;
      ra11 <= $signed(a1);
      db11 <= $signed(b1);
      ra21 <= $signed(a2);
      db12 <= $signed(b2);
    end
  end

  // ---------------- reference model ----------------
  function automatic int elem(input logic [4*DW-1:0] m, input int r, input int c);
    logic signed [DW-1:0] v;
    v = m[(3 - (2*r + c))*DW +: DW];
    return int'(v);
  endfunction

  function automatic logic [4*AW-1:0] matmul(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
    logic [4*AW-1:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 2; k++) s += elem(a, i, k) * elem(b, k, j);
        r[(3 - (2*i + j))*AW +: AW] = AW'(s);
      end
    return r;
  endfunction

  // Wavefront at feed cycle t: row i carries A[i][t-i], column j carries B[t-j][j].
  function automatic logic [4*DW-1:0] skew(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, input int t);
    logic [DW-1:0] av [2];
    logic [DW-1:0] bv [2];
    for (int i = 0; i < 2; i++) begin
      av[i] = (t - i >= 0 && t - i < 2) ? DW'(elem(a, i, t - i)) : '0;
      bv[i] = (t - i >= 0 && t - i < 2) ? DW'(elem(b, t - i, i)) : '0;
    end
    return {av[0], av[1], bv[0], bv[1]};
  endfunction

  function automatic logic [4*DW-1:0] pk8(input int e0, input int e1, input int e2, input int e3);
    return {DW'(e0), DW'(e1), DW'(e2), DW'(e3)};
  endfunction

  function automatic logic [4*AW-1:0] pk18(input int e0, input int e1, input int e2, input int e3);
    return {AW'(e0), AW'(e1), AW'(e2), AW'(e3)};
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full job from the start request to the done cycle, checked every cycle.
  // noisy adds start pulses in CLEAR, FEED1 and DRAIN and scrambles a_mat/b_mat.
  task automatic run_job(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                         input logic [4*AW-1:0] exp_c, input bit noisy, input string tag);
    a_mat = a;
    b_mat = b;
    start = 1'b1;
    step();                         // acceptance edge E, now in CLEAR
    start = noisy;
    if (noisy) begin
      a_mat = ~a;
      b_mat = ~b;
    end
    check({tag, " clear"}, {busy, array_clr, done, a1, a2, b1, b2}, {1'b1, 1'b1, 1'b0, 32'd0});
    for (int t = 0; t < 3; t++) begin
      step();
      start = noisy && (t == 1);
      check($sformatf("%s feed%0d", tag, t), {busy, array_clr, done, a1, a2, b1, b2},
            {1'b1, 1'b0, 1'b0, skew(a, b, t)});
    end
    for (int d = 0; d <= DRN; d++) begin
      step();
      start = noisy && (d == 1);
      check($sformatf("%s drain%0d", tag, d), {busy, array_clr, done, a1, a2, b1, b2},
            {1'b1, 1'b0, 1'b0, 32'd0});
    end
    step();                         // CAPTURE cycle
    check({tag, " capture"}, {array_clr, done, a1, a2, b1, b2}, {1'b0, 1'b0, 32'd0});
    step();                         // done cycle, E+6+DRN
    check({tag, " done"}, {busy, done, array_clr, a1, a2, b1, b2}, {1'b0, 1'b1, 1'b0, 32'd0});
    check({tag, " c_mat"}, c_mat, exp_c);
  endtask

  typedef struct {
    logic [4*DW-1:0] a;
    logic [4*DW-1:0] b;
    logic [4*AW-1:0] c;
    string           name;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [4*AW-1:0] held;
    logic [4*DW-1:0] ra, rb;

    tbl[0] = '{pk8(1, 2, 3, 4),         pk8(5, 6, 7, 8),         pk18(19, 22, 43, 50),         "basic"};
    tbl[1] = '{pk8(-1, 2, 3, -4),       pk8(5, -6, -7, 8),       pk18(-19, 22, 43, -50),       "signed"};
    tbl[2] = '{pk8(-128, -128, -128, -128), pk8(-128, -128, -128, -128), pk18(32768, 32768, 32768, 32768), "min_min"};
    tbl[3] = '{pk8(127, 127, 127, 127), pk8(127, 127, 127, 127), pk18(32258, 32258, 32258, 32258), "max_max"};
    tbl[4] = '{pk8(-128, -128, -128, -128), pk8(127, 127, 127, 127), pk18(-32512, -32512, -32512, -32512), "min_max"};
    tbl[5] = '{pk8(1, 0, 0, 1),         pk8(9, 8, 7, 6),         pk18(9, 8, 7, 6),             "identity"};

    rst   = 1'b0;
    start = 1'b0;
    a_mat = '0;
    b_mat = '0;
    step();
    step();
    check("reset state", {busy, done, array_clr, a1, a2, b1, b2, c_mat},
          {3'b000, 32'd0, 72'd0});
    rst = 1'b1;
    step();
    check("idle after reset", {busy, done, array_clr, a1, a2, b1, b2}, {3'b000, 32'd0});

    // Table-driven jobs, spaced by one idle cycle.
    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, tbl[i].name);
      step();
      check({tbl[i].name, " done pulse ends"}, {busy, done}, 2'b00);
    end

    // Back-to-back: second start issued in the done cycle of the first.
    run_job(tbl[0].a, tbl[0].b, tbl[0].c, 1'b0, "b2b first");
    run_job(tbl[5].a, tbl[5].b, tbl[5].c, 1'b0, "b2b second");
    step();
    check("b2b idle", {busy, done}, 2'b00);

    // Extra start pulses while busy are ignored; exactly one done.
    run_job(tbl[1].a, tbl[1].b, tbl[1].c, 1'b1, "noisy");
    for (int i = 0; i < 12; i++) begin
      step();
      check("noisy no second job", {busy, done, array_clr}, 3'b000);
    end
    check("noisy c_mat held", c_mat, tbl[1].c);

    // Reset during FEED1 aborts the job.
    a_mat = tbl[0].a;
    b_mat = tbl[0].b;
    start = 1'b1;
    step();                         // CLEAR
    start = 1'b0;
    step();                         // FEED0
    step();                         // FEED1
    check("pre-abort feed1", {a1, a2, b1, b2}, skew(tbl[0].a, tbl[0].b, 1));
    rst = 1'b0;
    step();
    check("abort outputs", {busy, done, array_clr, a1, a2, b1, b2, c_mat}, {3'b000, 32'd0, 72'd0});
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort no done", {busy, done, array_clr}, 3'b000);
    end
    run_job(tbl[1].a, tbl[1].b, tbl[1].c, 1'b0, "after abort");

    // Idle hold: nothing moves, c_mat keeps the last result.
    held = tbl[1].c;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle hold", {busy, done, array_clr, a1, a2, b1, b2, c_mat}, {3'b000, 32'd0, held});
    end

    // Randomized jobs against the matrix model, some back-to-back.
    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      rb = $urandom;
      run_job(ra, rb, matmul(ra, rb), n[2], $sformatf("rand%0d", n));
      if (n[0]) begin
        step();
        check("rand gap", {busy, done}, 2'b00);
      end
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
